regfile_param: RTL

Parametrised register file, successor to the team's fixed 16x8 block. Provides two combinational read ports, one write port with optional write-through bypass, and an optional hardwired-zero register 0. The 16 per-register outputs are replaced by a single indexed debug read port. A built-in clear sequencer zeroes the whole file on request, one register per cycle, with a busy handshake. Sits in the processor datapath between decode/ALU and writeback.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_clr_seq.sv | 59 +++++
 rtl/regfile_param.sv | 97 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
package regfile_pkg;

  // Clear sequencer states.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Address width for a given depth; never narrower than one bit.
  function automatic int aw_of(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: on request, walks an index across every register, one per cycle.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  // Next state: requests are only honoured in IDLE; the last index returns to IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        // Power-of-two depth means the increment wraps to 0 on exit.
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign busy    = (state_q == CLEAR);
  assign clr_en  = (state_q == CLEAR);
  assign clr_idx = idx_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: two read ports, one write port with optional
// bypass, optional hardwired-zero register 0, debug read port and clear sequencer.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = aw_of(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             clr_req,
  output logic             busy,
  output logic             wr_rej,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_rej_q, wr_rej_d;
  logic             clr_en;
  logic [AW-1:0]    clr_idx;
  logic             wr_act;
  logic             wr_ok;

  regfile_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  // A write is live only when the sequencer is idle; register 0 may be read-only.
  assign wr_act = we3 & ~busy;
  assign wr_ok  = wr_act & ~((ZERO_REG != 0) && (wa3 == '0));

  // Storage next state: a normal write or one clear step (never both, since writes need !busy).
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[wa3] = wd3;
    end
    if (clr_en) begin
      mem_d[clr_idx] = '0;
    end
  end

  // Rejection flag: any write attempted while the clear is running.
  always_comb begin
    wr_rej_d = we3 & busy;
  end

  // Storage and rejection flag; reset zeroes the whole file and aborts any clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_rej_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_rej_q <= wr_rej_d;
    end
  end

  assign wr_rej = wr_rej_q;

  // Read muxes: zero rule first, then same-cycle forwarding, then storage. Debug is never forwarded.
  always_comb begin
    rd1 = mem_q[ra1];
    if ((BYPASS != 0) && wr_act && (wa3 == ra1)) rd1 = wd3;
    if ((ZERO_REG != 0) && (ra1 == '0))          rd1 = '0;

    rd2 = mem_q[ra2];
    if ((BYPASS != 0) && wr_act && (wa3 == ra2)) rd2 = wd3;
    if ((ZERO_REG != 0) && (ra2 == '0))          rd2 = '0;

    dbg_data = mem_q[dbg_addr];
    if ((ZERO_REG != 0) && (dbg_addr == '0))     dbg_data = '0;
  end

endmodule
